// File: rtl/acc_core_pkg.sv
// core_pkg: shared types for the accumulator core.
//   OPC_BITS  - width of the opcode field at the top of each code word
//   opcode_t  - decoded instruction set (codes 6..14 are undefined)
//   state_t   - sequencer states
package core_pkg;

  localparam int unsigned OPC_BITS = 4;

  typedef enum logic [3:0] {
    OP_NOP  = 4'd0,
    OP_ADDI = 4'd1,
    OP_SUBI = 4'd2,
    OP_LDI  = 4'd3,
    OP_JMP  = 4'd4,
    OP_JZ   = 4'd5,
    OP_HALT = 4'd15
  } opcode_t;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_EXEC  = 2'd2,
    S_HALT  = 2'd3
  } state_t;

endpackage

// File: rtl/acc_core_alu.sv
// acc_core_alu: combinational execute stage of the accumulator core.
// Ports:
//   opcode    in  opcode field of the fetched word
//   imm       in  immediate field of the fetched word
//   acc       in  current accumulator
//   pc        in  current program counter
//   acc_next  out accumulator after this instruction
//   pc_next   out program counter after this instruction
//   illegal   out opcode is undefined (executed as NOP)
//   is_halt   out opcode is HALT
module acc_core_alu
  import core_pkg::*;
#(
  parameter int unsigned OP_WIDTH   = 16,
  parameter int unsigned ADDR_WIDTH = 9,
  parameter int unsigned ACC_WIDTH  = 32
) (
  input  logic [OPC_BITS-1:0]          opcode,
  input  logic [OP_WIDTH-OPC_BITS-1:0] imm,
  input  logic [ACC_WIDTH-1:0]         acc,
  input  logic [ADDR_WIDTH-1:0]        pc,
  output logic [ACC_WIDTH-1:0]         acc_next,
  output logic [ADDR_WIDTH-1:0]        pc_next,
  output logic                         illegal,
  output logic                         is_halt
);

  logic [ACC_WIDTH-1:0]  imm_acc;
  logic [ADDR_WIDTH-1:0] imm_pc;

  // Size casts zero-extend or truncate the immediate to each destination.
  assign imm_acc = ACC_WIDTH'(imm);
  assign imm_pc  = ADDR_WIDTH'(imm);

  always_comb begin
    acc_next = acc;
    pc_next  = pc + ADDR_WIDTH'(1);
    illegal  = 1'b0;
    is_halt  = 1'b0;
    // Unknown opcode values (e.g. uninitialised RAM) fall into default.
    case (opcode_t'(opcode))
      OP_NOP:  ;
      OP_ADDI: acc_next = acc + imm_acc;
      OP_SUBI: acc_next = acc - imm_acc;
      OP_LDI:  acc_next = imm_acc;
      OP_JMP:  pc_next  = imm_pc;
      OP_JZ:   if (acc == '0) pc_next = imm_pc;
      OP_HALT: begin
        pc_next = pc;
        is_halt = 1'b1;
      end
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/acc_core.sv
// acc_core: accumulator processor fetching opcodes from code RAM port B.
// Ports:
//   clock      in  core clock, rising edge
//   reset_n    in  synchronous active-low reset
//   run        in  level, free-running execution
//   step       in  pulse, execute one instruction while idle and run=0
//   clear      in  pulse, synchronous soft reset of architectural state
//   code_addr  out code RAM address (= pc)
//   code_we    out code RAM write enable, tied low
//   code_read  in  code RAM read data, one cycle after address
//   pc         out program counter
//   acc        out accumulator
//   retired    out saturating count of executed instructions
//   halted     out core is in S_HALT
//   illegal    out sticky undefined-opcode flag
//   led        out acc[3:0]
module acc_core
  import core_pkg::*;
#(
  parameter int unsigned OP_WIDTH   = 16,
  parameter int unsigned ADDR_WIDTH = 9,
  parameter int unsigned ACC_WIDTH  = 32,
  parameter int unsigned CNT_WIDTH  = 32
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  run,
  input  logic                  step,
  input  logic                  clear,
  output logic [ADDR_WIDTH-1:0] code_addr,
  output logic                  code_we,
  input  logic [OP_WIDTH-1:0]   code_read,
  output logic [ADDR_WIDTH-1:0] pc,
  output logic [ACC_WIDTH-1:0]  acc,
  output logic [CNT_WIDTH-1:0]  retired,
  output logic                  halted,
  output logic                  illegal,
  output logic [3:0]            led
);

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] pc_q, pc_d;
  logic [ACC_WIDTH-1:0]  acc_q, acc_d;
  logic [CNT_WIDTH-1:0]  retired_q, retired_d;
  logic                  illegal_q, illegal_d;
  logic                  single_q, single_d;

  logic [ACC_WIDTH-1:0]  alu_acc;
  logic [ADDR_WIDTH-1:0] alu_pc;
  logic                  alu_illegal;
  logic                  alu_halt;

  acc_core_alu #(
    .OP_WIDTH  (OP_WIDTH),
    .ADDR_WIDTH(ADDR_WIDTH),
    .ACC_WIDTH (ACC_WIDTH)
  ) u_alu (
    .opcode  (code_read[OP_WIDTH-1 -: OPC_BITS]),
    .imm     (code_read[OP_WIDTH-OPC_BITS-1:0]),
    .acc     (acc_q),
    .pc      (pc_q),
    .acc_next(alu_acc),
    .pc_next (alu_pc),
    .illegal (alu_illegal),
    .is_halt (alu_halt)
  );

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    acc_d     = acc_q;
    retired_d = retired_q;
    illegal_d = illegal_q;
    single_d  = single_q;
    if (clear) begin
      // Soft reset wins over any instruction in flight; it is not retired.
      state_d   = S_IDLE;
      pc_d      = '0;
      acc_d     = '0;
      retired_d = '0;
      illegal_d = 1'b0;
      single_d  = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (run) begin
            state_d  = S_FETCH;
            single_d = 1'b0;
          end else if (step) begin
            state_d  = S_FETCH;
            single_d = 1'b1;
          end
        end
        S_FETCH: state_d = S_EXEC;
        S_EXEC: begin
          pc_d      = alu_pc;
          acc_d     = alu_acc;
          illegal_d = illegal_q | alu_illegal;
          if (retired_q != '1) retired_d = retired_q + CNT_WIDTH'(1);
          if (alu_halt)                state_d = S_HALT;
          else if (single_q || !run)   state_d = S_IDLE;
          else                         state_d = S_FETCH;
        end
        S_HALT: state_d = S_HALT;
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q   <= S_IDLE;
      pc_q      <= '0;
      acc_q     <= '0;
      retired_q <= '0;
      illegal_q <= 1'b0;
      single_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      acc_q     <= acc_d;
      retired_q <= retired_d;
      illegal_q <= illegal_d;
      single_q  <= single_d;
    end
  end

  assign code_addr = pc_q;
  assign code_we   = 1'b0;
  assign pc        = pc_q;
  assign acc       = acc_q;
  assign retired   = retired_q;
  assign halted    = (state_q == S_HALT);
  assign illegal   = illegal_q;
  assign led       = acc_q[3:0];

endmodule
